// File: rtl/rf_bypass_sb.sv
// Decode-stage register file: NRD combinational read ports, one write port with
// write-to-read bypass, and a per-register pending-write scoreboard (credit counters).
//
// Parameters:
//   DATA_W  register width
//   NREG    architectural registers (<= 2**SEL_W)
//   SEL_W   register select width
//   NRD     number of read ports
//   CNT_W   pending counter width (max 2**CNT_W-1 outstanding writes per register)
//   R0_ZERO 1: register 0 reads as zero, is never written and is never pending
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rd_sel/rd_used       per-port read select (packed, SEL_W each) and consume flag
//   rd_data/rd_busy      per-port read data (packed, DATA_W each) and operand-owed flag
//   stall                some consumed operand is still owed
//   wr_en/wr_sel/wr_data writeback port
//   issue_en/issue_sel   destination of the instruction leaving decode
//   err                  sticky error (counter overflow or out-of-range select)
module rf_bypass_sb #(
    parameter int DATA_W  = 16,
    parameter int NREG    = 8,
    parameter int SEL_W   = 3,
    parameter int NRD     = 2,
    parameter int CNT_W   = 2,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*SEL_W-1:0]    rd_sel,
    input  logic [NRD-1:0]          rd_used,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    output logic                    stall,
    input  logic                    wr_en,
    input  logic [SEL_W-1:0]        wr_sel,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic                    issue_en,
    input  logic [SEL_W-1:0]        issue_sel,
    output logic                    err
);

    // One extra bit so the range check stays meaningful when NREG == 2**SEL_W.
    localparam logic [SEL_W:0]   NREG_W  = (SEL_W + 1)'(NREG);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [CNT_W-1:0]  cnt_q  [NREG];
    logic [CNT_W-1:0]  cnt_d  [NREG];
    logic              err_q;
    logic              err_d;

    logic              wr_live;
    logic              iss_live;
    logic              ovf;
    logic              rd_bad;
    logic [NRD-1:0]    busy_raw;

    function automatic logic sel_ok(input logic [SEL_W-1:0] s);
        return ({1'b0, s} < NREG_W);
    endfunction

    // A select that names real, writable, trackable storage.
    function automatic logic sel_live(input logic [SEL_W-1:0] s);
        return sel_ok(s) && !(R0_ZERO && (s == '0));
    endfunction

    assign wr_live  = wr_en && sel_live(wr_sel);
    assign iss_live = issue_en && sel_live(issue_sel);

    // Read ports with bypass and busy detection.
    always_comb begin
        logic [SEL_W-1:0] s;
        logic             byp;
        s        = '0;
        byp      = 1'b0;
        rd_data  = '0;
        busy_raw = '0;
        rd_bad   = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            s   = rd_sel[i*SEL_W +: SEL_W];
            byp = wr_live && (wr_sel == s);
            if (sel_live(s)) begin
                rd_data[i*DATA_W +: DATA_W] = byp ? wr_data : regs_q[s];
                // The last owed write arriving this cycle is already on the bypass.
                busy_raw[i] = (cnt_q[s] != '0) && !(byp && (cnt_q[s] == CNT_ONE));
            end
            if (!sel_ok(s) && rd_used[i]) begin
                rd_bad = 1'b1;
            end
        end
    end

    assign rd_busy = busy_raw & {NRD{~rst}};
    assign stall   = |(rd_busy & rd_used);
    assign err     = err_q;

    // Register write.
    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[wr_sel] = wr_data;
        end
    end

    // Scoreboard credit counters.
    always_comb begin
        logic hit_i;
        logic hit_w;
        hit_i = 1'b0;
        hit_w = 1'b0;
        ovf   = 1'b0;
        cnt_d = cnt_q;
        for (int r = 0; r < NREG; r++) begin
            hit_i = iss_live && (issue_sel == SEL_W'(r));
            hit_w = wr_live && (wr_sel == SEL_W'(r));
            unique case ({hit_i, hit_w})
                2'b10: begin
                    if (cnt_q[r] == CNT_MAX) begin
                        ovf = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] + CNT_ONE;
                    end
                end
                2'b01: begin
                    // A write with nothing owed is an untracked write.
                    if (cnt_q[r] != '0) begin
                        cnt_d[r] = cnt_q[r] - CNT_ONE;
                    end
                end
                2'b11: begin
                    // One credit retires, one is taken: a fresh owner if idle.
                    if (cnt_q[r] == '0) begin
                        cnt_d[r] = CNT_ONE;
                    end
                end
                default: begin
                    cnt_d[r] = cnt_q[r];
                end
            endcase
        end
    end

    always_comb begin
        err_d = err_q
              | ovf
              | rd_bad
              | (wr_en && !sel_ok(wr_sel))
              | (issue_en && !sel_ok(issue_sel));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_rf_bypass_sb.sv
// Testbench for rf_bypass_sb: default 2-port instance driven from a vector table,
// plus an R0_ZERO / 3-port instance driven by hand-written sequences.
module tb_rf_bypass_sb;

    logic        clk;
    int          checks;
    int          failures;

    // Default instance (NRD=2, R0_ZERO=0)
    logic        rst;
    logic [5:0]  rd_sel;
    logic [1:0]  rd_used;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        stall;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        issue_en;
    logic [2:0]  issue_sel;
    logic        err;

    // R0_ZERO=1, NRD=3 instance
    logic        z_rst;
    logic [8:0]  z_rd_sel;
    logic [2:0]  z_rd_used;
    logic [47:0] z_rd_data;
    logic [2:0]  z_rd_busy;
    logic        z_stall;
    logic        z_wr_en;
    logic [2:0]  z_wr_sel;
    logic [15:0] z_wr_data;
    logic        z_issue_en;
    logic [2:0]  z_issue_sel;
    logic        z_err;

    rf_bypass_sb u_dut (
        .clk(clk), .rst(rst),
        .rd_sel(rd_sel), .rd_used(rd_used),
        .rd_data(rd_data), .rd_busy(rd_busy), .stall(stall),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .issue_en(issue_en), .issue_sel(issue_sel),
        .err(err)
    );

    rf_bypass_sb #(.NRD(3), .R0_ZERO(1'b1)) u_z (
        .clk(clk), .rst(z_rst),
        .rd_sel(z_rd_sel), .rd_used(z_rd_used),
        .rd_data(z_rd_data), .rd_busy(z_rd_busy), .stall(z_stall),
        .wr_en(z_wr_en), .wr_sel(z_wr_sel), .wr_data(z_wr_data),
        .issue_en(z_issue_en), .issue_sel(z_issue_sel),
        .err(z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mask: bit0 data, bit1 busy/stall, bit2 err
    typedef struct {
        logic        rst;
        logic [2:0]  s0, s1;
        logic [1:0]  used;
        logic        we;
        logic [2:0]  ws;
        logic [15:0] wd;
        logic        ie;
        logic [2:0]  is;
        logic [15:0] d0, d1;
        logic [1:0]  busy;
        logic        stall;
        logic        err;
        logic [2:0]  mask;
    } vec_t;

    typedef struct {
        string       name;
        logic [47:0] data;
        logic [2:0]  busy;
        logic        stall;
        logic        err;
        logic [2:0]  mask;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t mk(
        input logic rs, input logic [2:0] s0, input logic [2:0] s1,
        input logic [1:0] used, input logic we, input logic [2:0] ws,
        input logic [15:0] wd, input logic ie, input logic [2:0] is,
        input logic [15:0] d0, input logic [15:0] d1, input logic [1:0] busy,
        input logic st, input logic er, input logic [2:0] mask);
        vec_t v;
        v.rst = rs; v.s0 = s0; v.s1 = s1; v.used = used;
        v.we = we; v.ws = ws; v.wd = wd; v.ie = ie; v.is = is;
        v.d0 = d0; v.d1 = d1; v.busy = busy; v.stall = st; v.err = er;
        v.mask = mask;
        return v;
    endfunction

    task automatic check(input string nm, input logic [47:0] act,
                         input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic compare(input exp_t e, input logic [47:0] data,
                           input logic [2:0] busy, input logic st,
                           input logic er);
        if (e.mask[0]) check({e.name, ".data"}, data, e.data);
        if (e.mask[1]) begin
            check({e.name, ".busy"}, 48'(busy), 48'(e.busy));
            check({e.name, ".stall"}, 48'(st), 48'(e.stall));
        end
        if (e.mask[2]) check({e.name, ".err"}, 48'(er), 48'(e.err));
    endtask

    task automatic zstep(
        input string nm, input logic rs, input logic [8:0] sel,
        input logic [2:0] used, input logic we, input logic [2:0] ws,
        input logic [15:0] wd, input logic ie, input logic [2:0] is,
        input logic [47:0] d, input logic [2:0] busy, input logic st,
        input logic er, input logic [2:0] mask);
        exp_t e;
        @(negedge clk);
        z_rst = rs; z_rd_sel = sel; z_rd_used = used;
        z_wr_en = we; z_wr_sel = ws; z_wr_data = wd;
        z_issue_en = ie; z_issue_sel = is;
        e.name = nm; e.data = d; e.busy = busy; e.stall = st;
        e.err = er; e.mask = mask;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        compare(e, z_rd_data, z_rd_busy, z_stall, z_err);
    endtask

    initial begin
        exp_t e;
        checks = 0;
        failures = 0;
        rst = 1'b1; rd_sel = '0; rd_used = '0; wr_en = 1'b0; wr_sel = '0;
        wr_data = '0; issue_en = 1'b0; issue_sel = '0;
        z_rst = 1'b1; z_rd_sel = '0; z_rd_used = '0; z_wr_en = 1'b0;
        z_wr_sel = '0; z_wr_data = '0; z_issue_en = 1'b0; z_issue_sel = '0;

        // reset, then bypass and stored read of r3
        tbl.push_back(mk(1, 0, 0, 2'b00, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    2'b00, 0, 0, 3'b010));
        tbl.push_back(mk(0, 0, 1, 2'b11, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    2'b00, 0, 0, 3'b111));
        tbl.push_back(mk(0, 3, 0, 2'b00, 1, 3, 16'hBEEF, 0, 0, 16'hBEEF, 16'h0,    2'b00, 0, 0, 3'b111));
        tbl.push_back(mk(0, 3, 0, 2'b00, 0, 0, 16'h0,    0, 0, 16'hBEEF, 16'h0,    2'b00, 0, 0, 3'b111));
        // issue r5, then busy, then bypass clears it
        tbl.push_back(mk(0, 3, 5, 2'b10, 0, 0, 16'h0,    1, 5, 16'hBEEF, 16'h0,    2'b00, 0, 0, 3'b111));
        tbl.push_back(mk(0, 3, 5, 2'b10, 0, 0, 16'h0,    0, 0, 16'hBEEF, 16'h0,    2'b10, 1, 0, 3'b111));
        tbl.push_back(mk(0, 3, 5, 2'b10, 1, 5, 16'h1234, 0, 0, 16'hBEEF, 16'h1234, 2'b00, 0, 0, 3'b111));
        tbl.push_back(mk(0, 3, 5, 2'b10, 0, 0, 16'h0,    0, 0, 16'hBEEF, 16'h1234, 2'b00, 0, 0, 3'b111));
        // r2: three issues, a fourth overflows, three writes drain
        tbl.push_back(mk(0, 2, 5, 2'b01, 0, 0, 16'h0,    1, 2, 16'h0,    16'h1234, 2'b00, 0, 0, 3'b111));
        tbl.push_back(mk(0, 2, 5, 2'b01, 0, 0, 16'h0,    1, 2, 16'h0,    16'h1234, 2'b01, 1, 0, 3'b111));
        tbl.push_back(mk(0, 2, 5, 2'b01, 0, 0, 16'h0,    1, 2, 16'h0,    16'h1234, 2'b01, 1, 0, 3'b111));
        tbl.push_back(mk(0, 2, 5, 2'b01, 0, 0, 16'h0,    1, 2, 16'h0,    16'h1234, 2'b01, 1, 0, 3'b111));
        tbl.push_back(mk(0, 2, 5, 2'b01, 0, 0, 16'h0,    0, 0, 16'h0,    16'h1234, 2'b01, 1, 1, 3'b111));
        tbl.push_back(mk(0, 2, 5, 2'b01, 1, 2, 16'h000A, 0, 0, 16'h000A, 16'h1234, 2'b01, 1, 1, 3'b111));
        tbl.push_back(mk(0, 2, 5, 2'b01, 1, 2, 16'h000B, 0, 0, 16'h000B, 16'h1234, 2'b01, 1, 1, 3'b111));
        tbl.push_back(mk(0, 2, 5, 2'b01, 1, 2, 16'h000C, 0, 0, 16'h000C, 16'h1234, 2'b00, 0, 1, 3'b111));
        tbl.push_back(mk(0, 2, 5, 2'b01, 0, 0, 16'h0,    0, 0, 16'h000C, 16'h1234, 2'b00, 0, 1, 3'b111));
        // r4: issue+write with cnt=1 keeps 1; with cnt=0 becomes 1
        tbl.push_back(mk(0, 4, 5, 2'b01, 0, 0, 16'h0,    1, 4, 16'h0,    16'h1234, 2'b00, 0, 1, 3'b111));
        tbl.push_back(mk(0, 4, 5, 2'b01, 1, 4, 16'h4444, 1, 4, 16'h4444, 16'h1234, 2'b00, 0, 1, 3'b111));
        tbl.push_back(mk(0, 4, 5, 2'b01, 0, 0, 16'h0,    0, 0, 16'h4444, 16'h1234, 2'b01, 1, 1, 3'b111));
        tbl.push_back(mk(0, 4, 5, 2'b01, 1, 4, 16'h5555, 0, 0, 16'h5555, 16'h1234, 2'b00, 0, 1, 3'b111));
        tbl.push_back(mk(0, 4, 5, 2'b01, 0, 0, 16'h0,    0, 0, 16'h5555, 16'h1234, 2'b00, 0, 1, 3'b111));
        tbl.push_back(mk(0, 4, 5, 2'b01, 1, 4, 16'h6666, 1, 4, 16'h6666, 16'h1234, 2'b00, 0, 1, 3'b111));
        tbl.push_back(mk(0, 4, 5, 2'b01, 0, 0, 16'h0,    0, 0, 16'h6666, 16'h1234, 2'b01, 1, 1, 3'b111));
        // mid-operation reset, then an untracked writeback
        tbl.push_back(mk(1, 4, 5, 2'b01, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    2'b00, 0, 0, 3'b010));
        tbl.push_back(mk(0, 4, 5, 2'b01, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0,    2'b00, 0, 0, 3'b111));
        tbl.push_back(mk(0, 4, 5, 2'b01, 1, 4, 16'h7777, 0, 0, 16'h7777, 16'h0,    2'b00, 0, 0, 3'b111));
        tbl.push_back(mk(0, 4, 4, 2'b11, 0, 0, 16'h0,    0, 0, 16'h7777, 16'h7777, 2'b00, 0, 0, 3'b111));
        // issue and write to different registers in one cycle
        tbl.push_back(mk(0, 1, 6, 2'b11, 1, 1, 16'h1111, 1, 6, 16'h1111, 16'h0,    2'b00, 0, 0, 3'b111));
        tbl.push_back(mk(0, 1, 6, 2'b11, 0, 0, 16'h0,    0, 0, 16'h1111, 16'h0,    2'b10, 1, 0, 3'b111));
        tbl.push_back(mk(0, 1, 6, 2'b01, 0, 0, 16'h0,    0, 0, 16'h1111, 16'h0,    2'b10, 0, 0, 3'b111));
        tbl.push_back(mk(0, 1, 6, 2'b11, 1, 6, 16'h6006, 0, 0, 16'h1111, 16'h6006, 2'b00, 0, 0, 3'b111));

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            rst = tbl[k].rst;
            rd_sel = {tbl[k].s1, tbl[k].s0};
            rd_used = tbl[k].used;
            wr_en = tbl[k].we; wr_sel = tbl[k].ws; wr_data = tbl[k].wd;
            issue_en = tbl[k].ie; issue_sel = tbl[k].is;
            e.name = $sformatf("v%0d", k);
            e.data = {16'h0, tbl[k].d1, tbl[k].d0};
            e.busy = {1'b0, tbl[k].busy};
            e.stall = tbl[k].stall;
            e.err = tbl[k].err;
            e.mask = tbl[k].mask;
            sb.push_back(e);
            #2;
            e = sb.pop_front();
            compare(e, {16'h0, rd_data}, {1'b0, rd_busy}, stall, err);
        end

        // R0_ZERO / 3-port sequences; sel packs {p2,p1,p0}
        zstep("z_rst",   1, {3'd0, 3'd0, 3'd0}, 3'b000, 0, 0, 16'h0,    0, 0,
              48'h0, 3'b000, 0, 0, 3'b010);
        zstep("z_idle",  0, {3'd7, 3'd1, 3'd0}, 3'b111, 0, 0, 16'h0,    0, 0,
              48'h0, 3'b000, 0, 0, 3'b111);
        zstep("z_r0wi",  0, {3'd0, 3'd0, 3'd0}, 3'b111, 1, 0, 16'hFFFF, 1, 0,
              48'h0, 3'b000, 0, 0, 3'b111);
        zstep("z_r0rd",  0, {3'd0, 3'd0, 3'd0}, 3'b111, 0, 0, 16'h0,    0, 0,
              48'h0, 3'b000, 0, 0, 3'b111);
        zstep("z_wr1",   0, {3'd7, 3'd1, 3'd1}, 3'b000, 1, 1, 16'h0101, 0, 0,
              {16'h0, 16'h0101, 16'h0101}, 3'b000, 0, 0, 3'b111);
        zstep("z_wr7",   0, {3'd7, 3'd1, 3'd1}, 3'b000, 1, 7, 16'h0707, 0, 0,
              {16'h0707, 16'h0101, 16'h0101}, 3'b000, 0, 0, 3'b111);
        zstep("z_rd117", 0, {3'd7, 3'd1, 3'd1}, 3'b111, 0, 0, 16'h0,    0, 0,
              {16'h0707, 16'h0101, 16'h0101}, 3'b000, 0, 0, 3'b111);
        zstep("z_iss7",  0, {3'd0, 3'd1, 3'd7}, 3'b001, 0, 0, 16'h0,    1, 7,
              {16'h0, 16'h0101, 16'h0707}, 3'b000, 0, 0, 3'b111);
        zstep("z_busy7", 0, {3'd0, 3'd1, 3'd7}, 3'b001, 0, 0, 16'h0,    0, 0,
              {16'h0, 16'h0101, 16'h0707}, 3'b001, 1, 0, 3'b111);

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
